// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data stages, data first with a fetch starvation guard
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_done,
    output logic [WIDTH-1:0] if_rdata,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    output logic             dm_done,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_mem
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
    state_t state;
    logic [CW-1:0] starve_cnt;
    logic at_limit, grant_dm, grant_if;
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = dm_req & ~dm_done;
    assign at_limit  = starve_cnt == CW'(STARVE_LIMIT);
    // a requester in its done cycle is masked, so the other side gets the free IDLE slot
    assign grant_dm  = stall_mem & (~stall_if | ~at_limit);
    assign grant_if  = stall_if & ~grant_dm;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state      <= BUSY_DM;
                        mem_req    <= 1'b1;
                        mem_we     <= dm_we;
                        mem_addr   <= dm_addr;
                        mem_wdata  <= dm_wdata;
                        starve_cnt <= stall_if ? (at_limit ? starve_cnt : starve_cnt + 1'b1) : '0;
                    end else if (grant_if) begin
                        state      <= BUSY_IF;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                    end
                end
                BUSY_IF: begin
                    if (mem_ready) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        if_done  <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                BUSY_DM: begin
                    if (mem_ready) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        dm_done  <= 1'b1;
                        dm_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a grant/completion scoreboard for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst, if_req, if_done, dm_req, dm_we, dm_done, mem_req, mem_we, mem_ready, stall_if, stall_mem;
    logic [W-1:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    int n_cmp = 0, n_err = 0;
    typedef struct {
        bit dm;
        bit we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] rdata;
    } exp_t;
    exp_t exp_q[$];
    exp_t cur;
    bit cur_v = 0, prev_req = 0;

    mem_port_arbiter #(.WIDTH(W), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic if_access(input logic [W-1:0] a, input int exp_n);
        int n = 0;
        if_addr = a;
        if_req  = 1'b1;
        while (n < 50) begin
            cyc();
            n++;
            if (if_done) break;
        end
        if_req = 1'b0;
        chk("if_latency", W'(n), W'(exp_n));
    endtask

    task automatic dm_access(input logic we, input logic [W-1:0] a, input logic [W-1:0] d, input int exp_n);
        int n = 0;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = d;
        dm_req   = 1'b1;
        while (n < 50) begin
            cyc();
            n++;
            if (dm_done) break;
        end
        dm_req = 1'b0;
        chk("dm_latency", W'(n), W'(exp_n));
    endtask

    // scoreboard monitor: pops an expected grant when mem_req rises, retires it at the done pulse
    always @(negedge clk) begin
        chk("done_exclusive", W'(if_done & dm_done), '0);
        if (rst) begin
            cur_v = 0;
        end else begin
            if (mem_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_grant: got addr %h want none", mem_addr);
                end else begin
                    cur   = exp_q.pop_front();
                    cur_v = 1;
                    chk("grant_we", W'(mem_we), W'(cur.we));
                end
            end
            if (mem_req && cur_v) begin
                chk("mem_addr", mem_addr, cur.addr);
                if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
            end
            if (if_done || dm_done) begin
                if (!cur_v) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_done: got if_done=%0b dm_done=%0b want none", if_done, dm_done);
                end else begin
                    chk("done_port", W'(dm_done), W'(cur.dm));
                    if (!cur.we) chk("rdata", dm_done ? dm_rdata : if_rdata, cur.rdata);
                    cur_v = 0;
                end
            end
        end
        prev_req = mem_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        repeat (2) cyc();
        chk("rst_mem_req", W'(mem_req), '0);
        chk("rst_mem_we", W'(mem_we), '0);
        chk("rst_if_done", W'(if_done), '0);
        chk("rst_dm_done", W'(dm_done), '0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_if_rdata", if_rdata, '0);
        chk("rst_dm_rdata", dm_rdata, '0);
        rst = 1'b0;
        cyc();
        // single zero-wait fetch
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        exp_q.push_back('{0, 0, 32'h10, 32'h0, 32'hDEADBEEF});
        if_addr = 32'h10;
        if_req  = 1'b1;
        #1;
        chk("c0_stall_if", W'(stall_if), 1);
        chk("c0_mem_req", W'(mem_req), '0);
        cyc();
        chk("c1_mem_req", W'(mem_req), 1);
        chk("c1_mem_addr", mem_addr, 32'h10);
        chk("c1_stall_if", W'(stall_if), 1);
        chk("c1_if_done", W'(if_done), '0);
        cyc();
        chk("c2_if_done", W'(if_done), 1);
        chk("c2_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("c2_stall_if", W'(stall_if), '0);
        if_req = 1'b0;
        cyc();
        // simultaneous requests: data write first, fetch in the following IDLE slot
        mem_rdata = 32'h12345678;
        exp_q.push_back('{1, 1, 32'h20, 32'h5, 32'h0});
        exp_q.push_back('{0, 0, 32'h30, 32'h0, 32'h12345678});
        fork
            if_access(32'h30, 4);
            dm_access(1'b1, 32'h20, 32'h5, 2);
        join
        cyc();
        // three data grants against a waiting fetch build up the starvation count
        for (int i = 0; i < 3; i++) begin
            mem_rdata = 32'h100 + i;
            exp_q.push_back('{1, 0, 32'h50 + i, 32'h0, 32'h100 + i});
            if_addr = 32'h40; if_req = 1'b1;
            dm_we = 1'b0; dm_addr = 32'h50 + i; dm_req = 1'b1;
            n = 0;
            while (n < 50) begin
                cyc();
                n++;
                if (dm_done) break;
            end
            chk("starve_dm_latency", W'(n), 2);
            if_req = 1'b0; dm_req = 1'b0;
            cyc();
        end
        mem_rdata = 32'h200;
        exp_q.push_back('{0, 0, 32'h40, 32'h0, 32'h200});
        exp_q.push_back('{1, 0, 32'h60, 32'h0, 32'h200});
        fork
            if_access(32'h40, 2);
            dm_access(1'b0, 32'h60, 32'h0, 4);
        join
        cyc();
        exp_q.push_back('{1, 0, 32'h61, 32'h0, 32'h200});
        exp_q.push_back('{0, 0, 32'h41, 32'h0, 32'h200});
        fork
            dm_access(1'b0, 32'h61, 32'h0, 2);
            if_access(32'h41, 4);
        join
        cyc();
        // wait states with requester fields changing mid-access
        mem_ready = 1'b0;
        exp_q.push_back('{1, 1, 32'h70, 32'hAB, 32'h0});
        fork
            dm_access(1'b1, 32'h70, 32'hAB, 7);
            begin
                cyc(); cyc();
                dm_addr = 32'h99; dm_wdata = 32'h77;
                repeat (4) cyc();
                mem_ready = 1'b1;
            end
        join
        repeat (3) cyc();
        // reset in the second BUSY_IF cycle together with mem_ready
        mem_ready = 1'b0;
        exp_q.push_back('{0, 0, 32'h80, 32'h0, 32'h0});
        if_addr = 32'h80; if_req = 1'b1;
        cyc();
        cyc();
        rst = 1'b1; mem_ready = 1'b1;
        cyc();
        rst = 1'b0; if_req = 1'b0;
        chk("abort_mem_req", W'(mem_req), '0);
        chk("abort_if_done", W'(if_done), '0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_abort_if_done", W'(if_done), '0);
            chk("post_abort_mem_req", W'(mem_req), '0);
        end
        mem_rdata = 32'hCAFE;
        exp_q.push_back('{1, 0, 32'h90, 32'h0, 32'hCAFE});
        dm_access(1'b0, 32'h90, 32'h0, 2);
        repeat (3) cyc();
        n_cmp++;
        if (exp_q.size() != 0 || cur_v) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size() + int'(cur_v));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
